// File: rtl/ser_data_sender_p.sv
// ser_data_sender_p: parametrised async-serial frame transmitter with valid/ready input.
// Define SER_SENDER_HOLD_EN to add a one-word holding register for gapless frames.
module ser_data_sender_p #(
    parameter int DATA_W      = 8,
    parameter int CLK_DIV     = 434,
    parameter int STOP_BITS   = 1,
    parameter int PARITY_MODE = 0,
    parameter int LSB_FIRST   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] data,
    input  logic              en,
    output logic              ready,
    output logic              busy,
    output logic              tx,
    output logic              tx_done
);

    if (DATA_W < 5 || DATA_W > 16 || CLK_DIV < 2 ||
        (STOP_BITS != 1 && STOP_BITS != 2) ||
        PARITY_MODE < 0 || PARITY_MODE > 2 ||
        (LSB_FIRST != 0 && LSB_FIRST != 1)) begin : g_bad_param
        $error("ser_data_sender_p: illegal parameter value");
    end

    localparam int DIV_W = $clog2(CLK_DIV);
    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam logic [DIV_W-1:0] DIV_MAX   = DIV_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t            state, state_n;
    logic [DIV_W-1:0]  div, div_n;
    logic [CNT_W-1:0]  cnt, cnt_n;
    logic [DATA_W-1:0] sh, sh_n;
    logic              par, par_n;
    logic              tx_q, tx_n;
    logic              done_q, done_n;
    logic              accept;
    logic              bit_end;

    function automatic logic front(input logic [DATA_W-1:0] w);
        return (LSB_FIRST != 0) ? w[0] : w[DATA_W-1];
    endfunction

    function automatic logic [DATA_W-1:0] shift(input logic [DATA_W-1:0] w);
        return (LSB_FIRST != 0) ? {1'b0, w[DATA_W-1:1]}
                                : {w[DATA_W-2:0], 1'b0};
    endfunction

    function automatic logic parity_of(input logic [DATA_W-1:0] w);
        return (PARITY_MODE == 2) ? ~(^w) : ^w;
    endfunction

`ifdef SER_SENDER_HOLD_EN
    logic [DATA_W-1:0] hold, hold_n;
    logic              hold_full, hold_full_n;

    assign ready = !hold_full;
`else
    assign ready = (state == IDLE);
`endif

    assign busy    = (state != IDLE);
    assign tx      = tx_q;
    assign tx_done = done_q;
    assign accept  = en && ready;
    assign bit_end = (div == DIV_MAX);

    always_comb begin
        state_n = state;
        div_n   = div;
        cnt_n   = cnt;
        sh_n    = sh;
        par_n   = par;
        tx_n    = tx_q;
        done_n  = 1'b0;
`ifdef SER_SENDER_HOLD_EN
        hold_n      = hold;
        hold_full_n = hold_full;
        // A word offered while a frame is running parks in the holding slot.
        if (accept && state != IDLE) begin
            hold_n      = data;
            hold_full_n = 1'b1;
        end
`endif
        unique case (state)
            IDLE: begin
                tx_n  = 1'b1;
                div_n = '0;
                cnt_n = '0;
`ifdef SER_SENDER_HOLD_EN
                if (hold_full) begin
                    state_n     = START;
                    tx_n        = 1'b0;
                    sh_n        = hold;
                    par_n       = parity_of(hold);
                    hold_full_n = 1'b0;
                end else if (accept) begin
`else
                if (accept) begin
`endif
                    state_n = START;
                    tx_n    = 1'b0;
                    sh_n    = data;
                    par_n   = parity_of(data);
                end
            end
            START: begin
                div_n = div + DIV_W'(1);
                if (bit_end) begin
                    div_n   = '0;
                    state_n = DATA;
                    tx_n    = front(sh);
                    sh_n    = shift(sh);
                end
            end
            DATA: begin
                div_n = div + DIV_W'(1);
                if (bit_end) begin
                    div_n = '0;
                    if (cnt == DATA_LAST) begin
                        cnt_n = '0;
                        if (PARITY_MODE != 0) begin
                            state_n = PARITY;
                            tx_n    = par;
                        end else begin
                            state_n = STOP;
                            tx_n    = 1'b1;
                        end
                    end else begin
                        cnt_n = cnt + CNT_W'(1);
                        tx_n  = front(sh);
                        sh_n  = shift(sh);
                    end
                end
            end
            PARITY: begin
                div_n = div + DIV_W'(1);
                if (bit_end) begin
                    div_n   = '0;
                    state_n = STOP;
                    tx_n    = 1'b1;
                end
            end
            STOP: begin
                div_n = div + DIV_W'(1);
                if (bit_end) begin
                    div_n = '0;
                    if (cnt == STOP_LAST) begin
                        cnt_n   = '0;
                        done_n  = 1'b1;
                        state_n = IDLE;
                        tx_n    = 1'b1;
`ifdef SER_SENDER_HOLD_EN
                        // Held word starts on the completion edge: no idle gap.
                        if (hold_full) begin
                            state_n     = START;
                            tx_n        = 1'b0;
                            sh_n        = hold;
                            par_n       = parity_of(hold);
                            hold_full_n = 1'b0;
                        end
`endif
                    end else begin
                        cnt_n = cnt + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_n = IDLE;
                tx_n    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            div    <= '0;
            cnt    <= '0;
            sh     <= '0;
            par    <= 1'b0;
            tx_q   <= 1'b1;
            done_q <= 1'b0;
        end else begin
            state  <= state_n;
            div    <= div_n;
            cnt    <= cnt_n;
            sh     <= sh_n;
            par    <= par_n;
            tx_q   <= tx_n;
            done_q <= done_n;
        end
    end

`ifdef SER_SENDER_HOLD_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            hold      <= '0;
            hold_full <= 1'b0;
        end else begin
            hold      <= hold_n;
            hold_full <= hold_full_n;
        end
    end
`endif

endmodule

// File: doc/ser_data_sender_p.md
Name: ser_data_sender_p

Overview:
Parametrised successor to the fixed 8-bit serial sender, generalising it to an async-serial (UART-style) frame transmitter.
- Configurable data width, bit period, parity mode, stop-bit count and bit order.
- Valid/ready handshake on the parallel side; idle-high `tx` line on the serial side; one-cycle `tx_done` pulse per frame.
- Sits between a byte/word producer and an external serial pin or loopback receiver.

Parameters:
- DATA_W, 8: payload bits per frame; legal 5..16.
- CLK_DIV, 434: clk cycles per serial bit; legal >= 2.
- STOP_BITS, 1: stop bits per frame; legal 1 or 2.
- PARITY_MODE, 0: 0 = none, 1 = even, 2 = odd.
- LSB_FIRST, 1: 1 = data LSB sent first, 0 = MSB first.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous reset, active-high.
- data  input  DATA_W  payload; sampled only on an accepting edge.
- en  input  1  request/valid; frame accepted on an edge where en && ready.
- ready  output  1  sender can accept a word this cycle.
- busy  output  1  frame in progress, i.e. state != IDLE.
- tx  output  1  serial line, registered, idle high.
- tx_done  output  1  one-cycle pulse at frame completion.

Behaviour:
- Reset values (rst high at an edge): tx = 1, ready = 1, busy = 0, tx_done = 0, state = IDLE, bit counter = 0, divider = 0. Reset overrides all other inputs, including mid-frame; the line returns high on the next edge, with no partial stop bit.
- States: IDLE -> START -> DATA -> PARITY -> STOP -> IDLE. PARITY is skipped when PARITY_MODE = 0.
- IDLE: ready = 1, tx = 1. On en && ready: latch data into the shift register, go to START, ready = 0. tx goes low on that same edge, so the start bit begins the cycle after acceptance.
- Each bit lasts exactly CLK_DIV cycles. The divider counts 0..CLK_DIV-1; the state/bit advances when the divider reaches CLK_DIV-1.
- DATA: DATA_W bits in the order set by LSB_FIRST; the bit counter wraps to 0 on exit.
- PARITY bit:
  - even mode: XOR of the latched payload;
  - odd mode: its inverse.
- STOP: tx = 1 for STOP_BITS * CLK_DIV cycles.
- Frame completion edge: state -> IDLE, ready -> 1, tx_done = 1 for exactly one cycle. A new en may be accepted on the edge after tx_done, giving minimum inter-frame idle = 1 cycle.
- Frame length from the accept edge to the tx_done edge = (1 + DATA_W + (PARITY_MODE != 0) + STOP_BITS) * CLK_DIV cycles.
- en while ready = 0 is ignored; data is not latched.
- Changes on data after acceptance do not affect the frame in flight.
- en held high continuously: frames back-to-back with a 1-cycle idle gap between them.
- Illegal parameter values: elaboration-time error via generate-time check; no runtime behaviour is defined.

Optional Feature:
- Macro SER_SENDER_HOLD_EN.
- Defined: adds a one-word holding register.
  - ready = !hold_full; a word can be accepted while busy.
  - At frame completion with hold_full, the held word loads directly into START on that same edge. tx stays high for no extra cycle, so the stop bit is followed immediately by the next start bit.
  - tx_done still pulses once per frame.
  - Reset clears hold_full.
- Undefined: no holding register; ready = !busy as described in Behaviour.

Test Plan:
- DATA_W=8, CLK_DIV=4, no parity, 1 stop; send 8'h0F -> tx sequence per 4 cycles: 0,1,1,1,1,0,0,0,0,1; tx_done pulses 40 cycles after the accept edge; ready low for those 40 cycles.
- PARITY_MODE=1 then 2; send 8'hAA -> parity bit 0 (even) and 1 (odd); frame = 44 cycles.
- LSB_FIRST=0, DATA_W=5, STOP_BITS=2; send 5'b10110 -> data bits 1,0,1,1,0 followed by 2 stop periods; tx_done after 32 cycles.
- Assert en during DATA with a different data value -> ignored; the in-flight frame is unchanged; no second tx_done until a new accept occurs.
- Pulse rst mid-DATA -> next edge: tx = 1, ready = 1, busy = 0, no tx_done; a subsequent send of 8'hEE is correct.
- With SER_SENDER_HOLD_EN: queue 8'h0F then 8'hAA while busy -> second start bit directly follows the first stop bit; two tx_done pulses exactly 40 cycles apart.
